// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_buffer
// Description : Circular trace capture of CPU IF-stage PC and WR-stage ALU
//               result. Arms on start, stops POST_N samples after a PC
//               trigger, then drains the frozen window over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int POST_N = 8
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       trig_pc,
  input  logic [31:0]       in_IF_PC,
  input  logic [31:0]       in_WR_ALUout,
  input  logic              tr_ready,
  output logic              tr_valid,
  output logic [79:0]       tr_data,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        state,
  output logic              trig_hit
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_N);

  // Sample storage is intentionally not reset; only the pointers are.
  logic [79:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] post_cnt;
  logic [15:0]       stamp;

  logic capturing;
  logic full;
  logic accept;

  assign capturing = ((state == S_ARMED) || (state == S_POST)) && !abort;
  assign full      = (count == CNT_FULL);
  assign tr_valid  = (state == S_DONE) && (count != '0);
  assign accept    = tr_valid && tr_ready;
  // Only a trigger can lead into POST/DONE, so state alone identifies a hit.
  assign trig_hit  = (state == S_POST) || (state == S_DONE);
  assign tr_data   = mem[rd_ptr];

  // Record one sample per cycle while capturing.
  always_ff @(posedge Clk) begin
    if (capturing) begin
      mem[wr_ptr] <= {stamp, in_IF_PC, in_WR_ALUout};
    end
  end

  // Capture/drain control: state, pointers, occupancy, stamp, post counter.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stamp    <= '0;
      post_cnt <= '0;
    end else if (abort) begin
      // Abort dominates every other request, including a coincident start.
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      if (capturing) begin
        wr_ptr <= wr_ptr + 1'b1;
        stamp  <= stamp + 16'd1;
        // A full buffer overwrites its oldest entry, so the read side follows.
        if (full) begin
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ARMED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            stamp  <= '0;
          end
        end
        S_ARMED: begin
          if (in_IF_PC == trig_pc) begin
            state    <= S_POST;
            post_cnt <= POST_INIT;
          end
        end
        S_POST: begin
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == ADDR_W'(1)) begin
            state <= S_DONE;
          end
        end
        default: begin
          if (start) begin
            state  <= S_ARMED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            stamp  <= '0;
          end else if (accept) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_trace_buffer
// Description : Directed self-checking bench for pipe_trace_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_trace_buffer;

  localparam logic [31:0] TRIG = 32'h0000_0010;

  logic        Clk;
  logic        Clrn;
  logic        start;
  logic        abort;
  logic [31:0] trig_pc;
  logic [31:0] in_IF_PC;
  logic [31:0] in_WR_ALUout;
  logic        tr_ready;
  logic        tr_valid;
  logic [79:0] tr_data;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        trig_hit;

  int total = 0;
  int bad   = 0;

  // Expected window: samples as driven, oldest first, capped at 16 entries.
  logic [79:0] sb[$];
  logic [15:0] stamp_m;

  pipe_trace_buffer #(.DEPTH(16), .ADDR_W(4), .POST_N(8)) dut (
    .Clk          (Clk),
    .Clrn         (Clrn),
    .start        (start),
    .abort        (abort),
    .trig_pc      (trig_pc),
    .in_IF_PC     (in_IF_PC),
    .in_WR_ALUout (in_WR_ALUout),
    .tr_ready     (tr_ready),
    .tr_valid     (tr_valid),
    .tr_data      (tr_data),
    .count        (count),
    .state        (state),
    .trig_hit     (trig_hit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    stamp_m = 16'd0;
    sb.delete();
  endtask

  task automatic write_one(input logic [31:0] pc);
    logic [31:0] alu;
    alu = pc ^ 32'hA5A5_0000 ^ {16'h0, stamp_m};
    in_IF_PC     = pc;
    in_WR_ALUout = alu;
    tick();
    sb.push_back({stamp_m, pc, alu});
    if (sb.size() > 16) void'(sb.pop_front());
    stamp_m = stamp_m + 16'd1;
  endtask

  // pre non-matching samples, the trigger sample, then 8 POST samples.
  task automatic capture(input int pre, input bit start_in_post);
    arm();
    chk("armed_state", {78'd0, state}, 80'd1);
    for (int i = 0; i < pre; i++) write_one(32'h8000_0000 + i);
    write_one(TRIG);
    chk("post_state", {78'd0, state}, 80'd2);
    for (int i = 0; i < 8; i++) begin
      start = start_in_post && (i == 3);
      // Odd POST samples repeat the trigger PC, which must be ignored.
      write_one(i[0] ? TRIG : 32'h4000_0000 + i);
      start = 1'b0;
    end
    chk("done_state", {78'd0, state}, 80'd3);
  endtask

  task automatic drain(input int n, input bit toggle);
    int acc;
    acc = 0;
    for (int c = 0; c < 200 && acc < n; c++) begin
      tr_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (tr_ready) begin
        chk("drain_valid", {79'd0, tr_valid}, 80'd1);
        if (tr_valid && sb.size() > 0) begin
          chk("drain_data", tr_data, sb.pop_front());
          acc++;
        end
      end
      tick();
    end
    tr_ready = 1'b0;
    chk("drain_accepts", 80'(acc), 80'(n));
  endtask

  initial begin
    Clrn = 1'b1; start = 1'b0; abort = 1'b0; trig_pc = TRIG;
    in_IF_PC = 32'h0; in_WR_ALUout = 32'h0; tr_ready = 1'b0; stamp_m = 16'd0;
    #2 Clrn = 1'b0;
    tick(); tick();
    chk("rst_state", {78'd0, state}, 80'd0);
    chk("rst_count", {75'd0, count}, 80'd0);
    chk("rst_valid", {79'd0, tr_valid}, 80'd0);
    chk("rst_hit", {79'd0, trig_hit}, 80'd0);
    Clrn = 1'b1;
    tick();

    // Short pre-window: trigger on the third ARMED cycle.
    capture(2, 1'b0);
    chk("short_count", {75'd0, count}, 80'd11);
    chk("short_hit", {79'd0, trig_hit}, 80'd1);
    chk("short_first_stamp", {64'd0, tr_data[79:64]}, 80'd0);
    drain(2, 1'b0);
    chk("short_trig_pc", {48'd0, tr_data[63:32]}, {48'd0, TRIG});
    chk("short_trig_stamp", {64'd0, tr_data[79:64]}, 80'd2);
    drain(5, 1'b0);
    chk("bp_count", {75'd0, count}, 80'd4);
    // Backpressure on the last four entries.
    drain(4, 1'b1);
    chk("bp_valid_end", {79'd0, tr_valid}, 80'd0);
    chk("bp_count_end", {75'd0, count}, 80'd0);
    chk("bp_state_end", {78'd0, state}, 80'd3);

    // Wrap/overwrite: 40 ARMED cycles before the trigger.
    capture(40, 1'b0);
    chk("wrap_count", {75'd0, count}, 80'd16);
    chk("wrap_first_stamp", {64'd0, tr_data[79:64]}, 80'd33);
    drain(7, 1'b0);
    chk("wrap_trig_pc", {48'd0, tr_data[63:32]}, {48'd0, TRIG});
    drain(9, 1'b0);
    chk("wrap_valid_end", {79'd0, tr_valid}, 80'd0);

    // start during POST ignored; then start+abort in DONE.
    capture(1, 1'b1);
    chk("col_count", {75'd0, count}, 80'd10);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("col_state", {78'd0, state}, 80'd0);
    chk("col_count_0", {75'd0, count}, 80'd0);
    chk("col_hit", {79'd0, trig_hit}, 80'd0);

    // Asynchronous reset in the middle of POST.
    arm();
    write_one(32'h0000_0100);
    write_one(TRIG);
    write_one(32'h0000_0200);
    chk("mid_post", {78'd0, state}, 80'd2);
    #2 Clrn = 1'b0;
    #1;
    chk("async_state", {78'd0, state}, 80'd0);
    chk("async_count", {75'd0, count}, 80'd0);
    chk("async_valid", {79'd0, tr_valid}, 80'd0);
    chk("async_hit", {79'd0, trig_hit}, 80'd0);
    tick();
    Clrn = 1'b1;
    tick();

    // Stamp wrap: 65540 ARMED cycles, window spans 0xFFFD..0x000C.
    capture(65540, 1'b0);
    chk("swrap_count", {75'd0, count}, 80'd16);
    chk("swrap_first", {64'd0, tr_data[79:64]}, 80'hFFFD);
    drain(3, 1'b0);
    chk("swrap_zero", {64'd0, tr_data[79:64]}, 80'h0000);
    drain(13, 1'b0);
    chk("swrap_valid_end", {79'd0, tr_valid}, 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Debug trace capture block that sits directly downstream of the 5-stage pipelined CPU top and consumes its observation outputs (IF-stage PC, WR-stage ALU result). Once armed, it records one sample per clock into a circular buffer, stops a programmable number of cycles after a PC trigger match, then drains the frozen window to a host over a valid/ready handshake. It is used for post-mortem inspection of hazard, stall and branch behaviour without stopping the CPU.

## Interface
- DEPTH, 16, buffer entries; power of two, ≥ 4
- ADDR_W, 4, log2(DEPTH)
- POST_N, 8, samples written after the trigger sample; 1 ≤ POST_N ≤ DEPTH-1
- Clk  in  1  single clock, rising edge
- Clrn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arm a new capture
- abort  in  1  one-cycle pulse; return to IDLE and discard contents
- trig_pc  in  32  PC value that fires the trigger
- in_IF_PC  in  32  CPU IF-stage PC
- in_WR_ALUout  in  32  CPU WR-stage ALU result
- tr_ready  in  1  host accepts tr_data
- tr_valid  out  1  tr_data holds an undrained entry
- tr_data  out  80  {stamp[15:0], PC[31:0], ALUout[31:0]} at read pointer
- count  out  ADDR_W+1  entries held, 0..DEPTH
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- trig_hit  out  1  high in POST and DONE of a triggered capture

## Operation
- Reset (Clrn=0, async): state=IDLE, wr_ptr=rd_ptr=0, count=0, stamp=0, post_cnt=0; outputs tr_valid=0, trig_hit=0, count=0, state=0; tr_data undefined-but-stable (memory not cleared).
- IDLE: no writes. start → ARMED; clears wr_ptr, rd_ptr, count, stamp.
- DONE: drain; start → ARMED (same clears, remaining entries discarded).
- ARMED: every cycle write {stamp, in_IF_PC, in_WR_ALUout} at wr_ptr; wr_ptr+1 mod DEPTH; count+1 saturating at DEPTH; if count==DEPTH before write, rd_ptr+1 mod DEPTH (oldest overwritten).
- Trigger: in ARMED, in_IF_PC==trig_pc → that cycle's sample is written, post_cnt←POST_N, state→POST.
- POST: write exactly as ARMED; post_cnt−1 per write; write with post_cnt==1 → DONE. Trigger matches ignored.
- DONE: no writes; tr_valid = (count≠0); tr_data = mem[rd_ptr]; tr_valid&tr_ready at edge → rd_ptr+1 mod DEPTH, count−1.
- tr_valid=0 in IDLE, ARMED, POST.
- stamp: 16-bit cycle counter, +1 each cycle in ARMED/POST, wraps 0xFFFF→0; frozen in IDLE/DONE.
- abort (any state) → IDLE, count=0, pointers=0, trig_hit=0. abort+start same cycle: abort wins.
- start in ARMED or POST ignored.
- Trigger window: after DONE, buffer holds min(pre+1+POST_N, DEPTH) entries, oldest first.

## Timing
- All state, pointers, counters update on rising Clk; only Clrn asynchronous.
- start edge: state=ARMED next cycle; first sample written on the following edge with stamp=0.
- Sample capture: inputs sampled at edge k are readable from memory after edge k.
- Trigger on edge k → POST from k; last POST write at edge k+POST_N, state=DONE after that edge.
- tr_data combinational from mem[rd_ptr]; tr_valid registered-state-derived; accept takes effect same edge, next entry presented next cycle (one entry per cycle max throughput).
- Host may hold tr_ready high continuously; tr_valid drops the cycle after count reaches 0.
- Reset mid-drain or mid-capture: immediate IDLE, contents discarded.

## Test plan
- Reset: Clrn=0 mid-POST → state=0, count=0, tr_valid=0, trig_hit=0 immediately (before next edge).
- Short pre-window: start, trig_pc=0x0000_0010 matched on 3rd ARMED cycle, POST_N=8 → DONE with count=11; drain returns stamps 0..10 in order, entry 2 PC=0x10.
- Wrap/overwrite: trigger after 40 ARMED cycles, DEPTH=16, POST_N=8 → count=16; first drained stamp=33, last=48, trigger entry at drain index 7.
- Backpressure: DONE, count=4, tr_ready toggling 1,0,1,0,… → exactly 4 accepts, no duplicates/skips, tr_valid=0 after 4th.
- Control collisions: start+abort same cycle in DONE → IDLE, count=0; start during POST → ignored, completes to DONE.
- Stamp wrap: 65540 ARMED cycles then trigger → stamps roll 0xFFFF→0x0000 consecutively in drained data.
